player_ctrl_multi: RTL
======================

Name: player_ctrl_multi

Overview:
Parametrised playback controller for the music player: owns transport state, song index, playback position and volume for N_SONGS tracks.
- Sits between the debounced front-panel buttons and the audio datapath / 7-segment display drivers.
- Adds over the single-track player: configurable seek steps, song-count wrap, repeat modes, auto-advance at end of track, smart "previous", and held-button edge detection.

Parameters:
N_SONGS, 4, number of tracks; song index width SONG_W = clog2(N_SONGS), minimum 1
TIME_W, 10, width of position and song length, in seconds
SHORT_STEP, 10, short seek step in seconds
LONG_STEP, 30, long seek step in seconds
VOL_MAX, 7, highest volume level; VOL_W = clog2(VOL_MAX+1)
VOL_DEFAULT, 3, volume level after reset
PREV_RESTART_SEC, 3, position threshold for "previous"

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick_1s  in  1  one-clk pulse per second, already synchronous to clk
play_pause  in  1  level button
next_song  in  1  level button
prev_song  in  1  level button
pass_10s  in  1  level button, short seek forward
back_10s  in  1  level button, short seek back
pass_30s  in  1  level button, long seek forward
back_30s  in  1  level button, long seek back
aumenta_volume  in  1  level button, volume up
diminui_volume  in  1  level button, volume down
mute_btn  in  1  level button, mute toggle
repeat_btn  in  1  level button, cycles repeat mode
song_len  in  TIME_W  length of current song_idx (external ROM, combinational)
state  out  2  0 STOPPED, 1 PLAYING, 2 PAUSED
song_idx  out  SONG_W  current track
pos_sec  out  TIME_W  elapsed seconds in current track
vol_level  out  VOL_W  stored volume
vol_out  out  VOL_W  0 when muted, else vol_level
muted  out  1  mute flag
repeat_mode  out  2  0 OFF, 1 ALL, 2 ONE
track_end  out  1  one-cycle pulse on auto-advance or end stop

Behaviour:
- Reset (async, rst_n=0): state STOPPED, song_idx 0, pos_sec 0, vol_level VOL_DEFAULT, muted 0, repeat_mode OFF, track_end 0, all button history registers 0.
- Buttons: rising edge is detected against a registered copy (press = btn & ~btn_q). Action takes effect on that same clk edge, so outputs change 1 cycle after the input rises. A held button yields exactly one action.
- play_pause: STOPPED->PLAYING, PLAYING->PAUSED, PAUSED->PLAYING.
- Track/seek group: at most one action per cycle. Priority: next > prev > pass_30s > back_30s > pass_10s > back_10s.
- next: song_idx+1, wrapping N_SONGS-1 -> 0; pos_sec 0; state unchanged.
- prev: if pos_sec >= PREV_RESTART_SEC, pos_sec 0 and same song. Otherwise song_idx-1, wrapping 0 -> N_SONGS-1, and pos_sec 0.
- Seeks: ignored in STOPPED.
  - Forward: pos+step, clamped to L-1, where L = max(song_len,1).
  - Back: saturates at 0.
  - Arithmetic is TIME_W+1 wide; no wrap.
- tick_1s, in PLAYING with no track/seek action in the same cycle: if pos_sec+1 < L, increment. Otherwise end of track; track_end=1 for one cycle and:
  - ONE: pos 0, same song.
  - song_idx < N_SONGS-1: song+1, pos 0.
  - ALL: song 0, pos 0.
  - OFF on last song: state STOPPED, pos 0, song unchanged.
- tick in the same cycle as a track/seek action: tick discarded; the action wins.
- tick in PAUSED or STOPPED: ignored.
- play_pause is independent of the track/seek group and applies in the same cycle. A tick in that cycle is evaluated against the pre-edge state.
- Volume: aumenta_volume has priority over diminui_volume. Up saturates at VOL_MAX; down saturates at 0. The mute flag is unaffected by volume changes.
- mute_btn toggles muted, independently of volume presses in the same cycle.
- repeat_btn: OFF->ALL->ONE->OFF.
- song_len changes combinationally with song_idx. The clamp/compare uses the song_len value present at the clock edge.

Test Plan:
- Reset mid-play at pos 25, then release -> STOPPED, song 0, pos 0, vol 3, vol_out 3, repeat OFF, within the reset assertion, not clock-dependent.
- play_pause held 10 cycles -> state PLAYING exactly once. Then 5 ticks -> pos_sec 5. play_pause -> PAUSED, and further ticks leave pos at 5.
- song_len=40, pos 5: pass_30s -> 35; pass_10s -> 39 (clamped); back_30s -> 9; back_10s twice -> 0 (saturated).
- N_SONGS=4, song 3: next -> song 0. pos 2: prev -> song 3. pos 10: prev -> pos 0, song stays 3.
- song_len=3, song 3, repeat OFF, PLAYING: 3 ticks -> track_end pulse, STOPPED, pos 0. Repeat ALL -> song 0. Repeat ONE -> same song, pos 0.
- vol_up 6 times from 3 -> 7 (saturated); mute -> vol_out 0, vol_level 7. Same-cycle next + tick at pos 4 -> song+1, pos 0, no track_end.

Source files
------------

// File: rtl/player_ctrl_multi.sv
// Playback controller: transport state, track index, position, volume and repeat mode.
// Every output comes from a register. vol_out is the only combinational output, and it depends only on registers.
module player_ctrl_multi #(
  parameter int N_SONGS          = 4,
  parameter int TIME_W           = 10,
  parameter int SHORT_STEP       = 10,
  parameter int LONG_STEP        = 30,
  parameter int VOL_MAX          = 7,
  parameter int VOL_DEFAULT      = 3,
  parameter int PREV_RESTART_SEC = 3,
  localparam int SONG_W = (N_SONGS > 1) ? $clog2(N_SONGS) : 1,
  localparam int VOL_W  = (VOL_MAX > 0) ? $clog2(VOL_MAX + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1s,
  input  logic              play_pause,
  input  logic              next_song,
  input  logic              prev_song,
  input  logic              pass_10s,
  input  logic              back_10s,
  input  logic              pass_30s,
  input  logic              back_30s,
  input  logic              aumenta_volume,
  input  logic              diminui_volume,
  input  logic              mute_btn,
  input  logic              repeat_btn,
  input  logic [TIME_W-1:0] song_len,
  output logic [1:0]        state,
  output logic [SONG_W-1:0] song_idx,
  output logic [TIME_W-1:0] pos_sec,
  output logic [VOL_W-1:0]  vol_level,
  output logic [VOL_W-1:0]  vol_out,
  output logic              muted,
  output logic [1:0]        repeat_mode,
  output logic              track_end
);

  localparam int TW1 = TIME_W + 1;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_PLAYING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_t;

  localparam logic [1:0]        REP_OFF   = 2'd0;
  localparam logic [1:0]        REP_ALL   = 2'd1;
  localparam logic [1:0]        REP_ONE   = 2'd2;
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(N_SONGS - 1);
  localparam logic [TW1-1:0]    SHORT_W   = TW1'(SHORT_STEP);
  localparam logic [TW1-1:0]    LONG_W    = TW1'(LONG_STEP);
  localparam logic [TW1-1:0]    PREV_W    = TW1'(PREV_RESTART_SEC);
  localparam logic [VOL_W-1:0]  VOL_TOP   = VOL_W'(VOL_MAX);
  localparam logic [VOL_W-1:0]  VOL_DEF   = VOL_W'(VOL_DEFAULT);

  // Button bit order:
  //   0 play/pause, 1 next, 2 prev, 3 pass10, 4 back10, 5 pass30,
  //   6 back30, 7 vol up, 8 vol down, 9 mute, 10 repeat
  logic [10:0] btn, btn_q, press;
  assign btn = {repeat_btn, mute_btn, diminui_volume, aumenta_volume, back_30s,
                pass_30s, back_10s, pass_10s, prev_song, next_song, play_pause};
  assign press = btn & ~btn_q;

  state_t            state_q;
  logic [SONG_W-1:0] song_q;
  logic [TIME_W-1:0] pos_q;
  logic [VOL_W-1:0]  vol_q;
  logic              muted_q;
  logic [1:0]        rep_q;
  logic              te_q;

  logic [TW1-1:0] len_eff, last_pos, pos_ext, pos_inc, seek_pos;
  logic           seek_p;

  // A zero-length ROM entry is treated as a one-second track, so that last_pos never underflows.
  assign len_eff  = (song_len == '0) ? TW1'(1) : {1'b0, song_len};
  assign last_pos = len_eff - TW1'(1);
  assign pos_ext  = {1'b0, pos_q};
  assign pos_inc  = pos_ext + TW1'(1);

  function automatic logic [TW1-1:0] seek_fwd(input logic [TW1-1:0] p,
                                              input logic [TW1-1:0] step,
                                              input logic [TW1-1:0] lim);
    logic [TW1-1:0] s;
    s = p + step;
    return (s > lim) ? lim : s;
  endfunction

  function automatic logic [TW1-1:0] seek_back(input logic [TW1-1:0] p,
                                               input logic [TW1-1:0] step);
    return (p >= step) ? (p - step) : '0;
  endfunction

  always_comb begin
    seek_p   = 1'b1;
    seek_pos = pos_ext;
    if (press[5])      seek_pos = seek_fwd(pos_ext, LONG_W, last_pos);
    else if (press[6]) seek_pos = seek_back(pos_ext, LONG_W);
    else if (press[3]) seek_pos = seek_fwd(pos_ext, SHORT_W, last_pos);
    else if (press[4]) seek_pos = seek_back(pos_ext, SHORT_W);
    else               seek_p   = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= '0;
      state_q <= ST_STOPPED;
      song_q  <= '0;
      pos_q   <= '0;
      vol_q   <= VOL_DEF;
      muted_q <= 1'b0;
      rep_q   <= REP_OFF;
      te_q    <= 1'b0;
    end else begin
      btn_q <= btn;
      te_q  <= 1'b0;

      if (press[0]) begin
        case (state_q)
          ST_PLAYING: state_q <= ST_PAUSED;
          default:    state_q <= ST_PLAYING;
        endcase
      end

      // The track/seek group blocks the tick. An end-of-track stop assigns state_q later in this block, so it overrides play/pause.
      if (press[1]) begin
        song_q <= (song_q == LAST_SONG) ? '0 : song_q + SONG_W'(1);
        pos_q  <= '0;
      end else if (press[2]) begin
        pos_q <= '0;
        if (pos_ext < PREV_W)
          song_q <= (song_q == '0) ? LAST_SONG : song_q - SONG_W'(1);
      end else if (seek_p && state_q != ST_STOPPED) begin
        pos_q <= seek_pos[TIME_W-1:0];
      end else if (tick_1s && state_q == ST_PLAYING) begin
        if (pos_inc < len_eff) begin
          pos_q <= pos_inc[TIME_W-1:0];
        end else begin
          te_q  <= 1'b1;
          pos_q <= '0;
          if (rep_q != REP_ONE) begin
            if (song_q < LAST_SONG)   song_q  <= song_q + SONG_W'(1);
            else if (rep_q == REP_ALL) song_q <= '0;
            else                       state_q <= ST_STOPPED;
          end
        end
      end

      if (press[7]) begin
        if (vol_q != VOL_TOP) vol_q <= vol_q + VOL_W'(1);
      end else if (press[8]) begin
        if (vol_q != '0) vol_q <= vol_q - VOL_W'(1);
      end

      if (press[9]) muted_q <= ~muted_q;

      if (press[10]) begin
        case (rep_q)
          REP_OFF: rep_q <= REP_ALL;
          REP_ALL: rep_q <= REP_ONE;
          default: rep_q <= REP_OFF;
        endcase
      end
    end
  end

  assign state       = state_q;
  assign song_idx    = song_q;
  assign pos_sec     = pos_q;
  assign vol_level   = vol_q;
  assign vol_out     = muted_q ? '0 : vol_q;
  assign muted       = muted_q;
  assign repeat_mode = rep_q;
  assign track_end   = te_q;

endmodule
